// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480 @ 800x525) and the lock FSM state encoding
// used by the pattern checker and its expected-pixel generator.
package vga_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_TOTAL_DEF   = 800;
  localparam int HSYNC_X_DEF   = 657;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_TOTAL_DEF   = 525;
  localparam int VSYNC_Y_DEF   = 490;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_expected_pixel.sv
// Reference test pattern: red grid every 8 pixels/lines, green band on y[4],
// blue band on x[4]; black outside the active window.
module vga_expected_pixel
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [2:0] rgb
);

  logic active;

  always_comb begin
    active = (x < 10'(H_DISPLAY)) && (y < 10'(V_DISPLAY));
    rgb[0] = active && ((x[2:0] == 3'd0) || (y[2:0] == 3'd0));
    rgb[1] = active && y[4];
    rgb[2] = active && x[4];
  end

endmodule

// File: rtl/vga_pattern_checker.sv
// VGA timing lock + test-pattern checker. Define VGA_PATTERN_CHECK_EN to compile in
// the per-pixel comparison; without it only sync timing is checked.
module vga_pattern_checker
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY   = H_DISPLAY_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int HSYNC_X     = HSYNC_X_DEF,
  parameter int V_DISPLAY   = V_DISPLAY_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int VSYNC_Y     = VSYNC_Y_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic        locked,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] pix_err_count,
  output logic [7:0]  sync_err_count
);

  logic        hs_reg, vs_reg, hs_prev_reg;
  logic [2:0]  rgb_reg;
  logic        vs_at_hs_reg;   // vsync as seen at the previous hsync rising edge
  logic        hs_seen_reg;    // an hsync edge has been seen since reset
  logic [9:0]  x_reg, y_reg;
  logic [11:0] line_cnt_reg;
  logic [10:0] frame_lines_reg;
  logic [7:0]  good_frames_reg;
  logic        mismatch_seen_reg;
  lock_state_t state_reg;

  logic       hs_rise, v_edge, line_good, frame_good, x_aligned, mismatch;
  logic [2:0] exp_rgb;

  assign hs_rise    = hs_reg & ~hs_prev_reg;
  assign v_edge     = hs_rise & hs_seen_reg & vs_reg & ~vs_at_hs_reg;
  assign line_good  = hs_seen_reg && (line_cnt_reg == 12'(H_TOTAL));
  assign frame_good = (frame_lines_reg == 11'(V_TOTAL));
  assign x_aligned  = (x_reg == 10'(HSYNC_X));
  assign locked     = (state_reg == LOCKED);

  vga_expected_pixel #(
    .H_DISPLAY(H_DISPLAY),
    .V_DISPLAY(V_DISPLAY)
  ) u_expected (
    .x  (x_reg),
    .y  (y_reg),
    .rgb(exp_rgb)
  );

`ifdef VGA_PATTERN_CHECK_EN
  assign mismatch = (state_reg == LOCKED) && (rgb_reg != exp_rgb);
`else
  logic check_unused;
  assign check_unused = ^{rgb_reg, exp_rgb};
  assign mismatch     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_reg            <= 1'b0;
      vs_reg            <= 1'b0;
      hs_prev_reg       <= 1'b0;
      rgb_reg           <= '0;
      vs_at_hs_reg      <= 1'b0;
      hs_seen_reg       <= 1'b0;
      x_reg             <= '0;
      y_reg             <= '0;
      line_cnt_reg      <= '0;
      frame_lines_reg   <= '0;
      good_frames_reg   <= '0;
      mismatch_seen_reg <= 1'b0;
      state_reg         <= UNLOCKED;
      frame_done        <= 1'b0;
      frame_ok          <= 1'b0;
      pix_err_count     <= '0;
      sync_err_count    <= '0;
    end else begin
      hs_reg      <= hsync;
      vs_reg      <= vsync;
      rgb_reg     <= rgb;
      hs_prev_reg <= hs_reg;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;

      // The edge sample itself is position HSYNC_X, so the next one is HSYNC_X+1.
      if (hs_rise) begin
        x_reg <= 10'(HSYNC_X + 1);
        if (v_edge) y_reg <= 10'(VSYNC_Y);
      end else if (x_reg == 10'(H_TOTAL - 1)) begin
        x_reg <= '0;
        y_reg <= (y_reg == 10'(V_TOTAL - 1)) ? '0 : y_reg + 10'd1;
      end else begin
        x_reg <= x_reg + 10'd1;
      end

      if (hs_rise) begin
        hs_seen_reg     <= 1'b1;
        vs_at_hs_reg    <= vs_reg;
        line_cnt_reg    <= 12'd1;
        frame_lines_reg <= v_edge ? 11'd1 :
                           (frame_lines_reg == '1) ? frame_lines_reg : frame_lines_reg + 11'd1;
      end else if (line_cnt_reg != '1) begin
        line_cnt_reg <= line_cnt_reg + 12'd1;
      end

      if (v_edge)        mismatch_seen_reg <= 1'b0;
      else if (mismatch) mismatch_seen_reg <= 1'b1;

      if (mismatch && (pix_err_count != '1)) pix_err_count <= pix_err_count + 16'd1;

      case (state_reg)
        UNLOCKED: begin
          if (v_edge) begin
            state_reg       <= ACQUIRE;
            good_frames_reg <= '0;
          end
        end
        ACQUIRE: begin
          if (hs_rise) begin
            if (!line_good || (v_edge && !frame_good)) begin
              state_reg <= UNLOCKED;
            end else if (v_edge) begin
              if (good_frames_reg == 8'(LOCK_FRAMES - 1)) begin
                state_reg  <= LOCKED;
                frame_done <= 1'b1;
                frame_ok   <= !(mismatch_seen_reg || mismatch);
              end else begin
                good_frames_reg <= good_frames_reg + 8'd1;
              end
            end
          end
        end
        LOCKED: begin
          if (hs_rise) begin
            // Losing lock suppresses this edge's frame_done.
            if (!line_good || !x_aligned || (v_edge && !frame_good)) begin
              state_reg <= UNLOCKED;
              if (sync_err_count != '1) sync_err_count <= sync_err_count + 8'd1;
            end else if (v_edge) begin
              frame_done <= 1'b1;
              frame_ok   <= !(mismatch_seen_reg || mismatch);
            end
          end
        end
        default: state_reg <= UNLOCKED;
      endcase
    end
  end

endmodule
